// File: rtl/cache_data_ways_pkg.sv
// Shared types for the set-associative cache data store: access sizes and
// the line-transfer sequencer states.
package cache_data_ways_pkg;

    typedef enum logic [1:0] {
        BYTE = 2'd0,
        HALF = 2'd1,
        WORD = 2'd2
    } memory_operation_size_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        EVICT = 2'd2
    } cache_data_state_e;

    localparam int BYTE_WIDTH = 8;
    localparam int HALF_WIDTH = 16;

endpackage

// File: rtl/cache_data_ways_load_extend.sv
// Selects the addressed byte/half/word out of a stored word and sign- or
// zero-extends it to the full load width.
module cache_data_ways_load_extend
    import cache_data_ways_pkg::*;
#(
    parameter int XLEN             = 32,
    parameter int BYTE_SELECT_SIZE = 2
) (
    input  logic [XLEN-1:0]             word_i,
    input  logic [BYTE_SELECT_SIZE-1:0] byte_sel_i,
    input  memory_operation_size_e      size_i,
    input  logic                        unsigned_i,
    output logic [XLEN-1:0]             data_o
);

    logic [BYTE_WIDTH-1:0] byte_val;
    logic [HALF_WIDTH-1:0] half_val;
    logic                  byte_sign;
    logic                  half_sign;

    always_comb begin
        byte_val  = word_i[{byte_sel_i, 3'b000} +: BYTE_WIDTH];
        // Halves are taken from the aligned pair; misaligned loads are discarded upstream.
        half_val  = word_i[{byte_sel_i[BYTE_SELECT_SIZE-1:1], 4'b0000} +: HALF_WIDTH];
        byte_sign = byte_val[BYTE_WIDTH-1] & ~unsigned_i;
        half_sign = half_val[HALF_WIDTH-1] & ~unsigned_i;
        case (size_i)
            BYTE:    data_o = {{(XLEN-BYTE_WIDTH){byte_sign}}, byte_val};
            HALF:    data_o = {{(XLEN-HALF_WIDTH){half_sign}}, half_val};
            default: data_o = word_i;
        endcase
    end

endmodule

// File: rtl/cache_data_ways.sv
// Set-associative cache data array: core byte/half/word loads and stores plus
// a sequencer that streams whole lines in (fill) and out (evict).
module cache_data_ways
    import cache_data_ways_pkg::*;
#(
    parameter int XLEN           = 32,
    parameter int NUM_WAYS       = 2,
    parameter int NUM_SETS       = 4,
    parameter int WORDS_PER_LINE = 8,
    localparam int WAY_SIZE         = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1,
    localparam int SET_SIZE         = $clog2(NUM_SETS),
    localparam int WORD_SELECT_SIZE = $clog2(WORDS_PER_LINE),
    localparam int BYTE_SELECT_SIZE = $clog2(XLEN / 8)
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        req_valid,
    output logic                        req_ready,
    input  logic                        req_write,
    input  logic [SET_SIZE-1:0]         req_set,
    input  logic [WAY_SIZE-1:0]         req_way,
    input  logic [WORD_SELECT_SIZE-1:0] req_word,
    input  logic [BYTE_SELECT_SIZE-1:0] req_byte,
    input  memory_operation_size_e      req_size,
    input  logic                        req_unsigned,
    input  logic [XLEN-1:0]             req_wdata,
    output logic                        rsp_valid,
    output logic [XLEN-1:0]             rsp_rdata,
    output logic                        rsp_misaligned,
    input  logic                        fill_start,
    input  logic [SET_SIZE-1:0]         fill_set,
    input  logic [WAY_SIZE-1:0]         fill_way,
    input  logic                        fill_valid,
    input  logic [XLEN-1:0]             fill_data,
    output logic                        fill_done,
    input  logic                        evict_start,
    input  logic [SET_SIZE-1:0]         evict_set,
    input  logic [WAY_SIZE-1:0]         evict_way,
    output logic                        evict_valid,
    input  logic                        evict_ready,
    output logic [XLEN-1:0]             evict_data,
    output logic                        evict_last
);

    localparam int LANES  = XLEN / 8;
    localparam int ADDR_W = WAY_SIZE + SET_SIZE + WORD_SELECT_SIZE;
    localparam int DEPTH  = 1 << ADDR_W;
    localparam logic [WORD_SELECT_SIZE-1:0] LAST_WORD = WORD_SELECT_SIZE'(WORDS_PER_LINE - 1);

    cache_data_state_e           state_q, state_d;
    logic [WORD_SELECT_SIZE-1:0] cnt_q, cnt_d;
    logic [SET_SIZE-1:0]         line_set_q, line_set_d;
    logic [WAY_SIZE-1:0]         line_way_q, line_way_d;
    logic                        fill_done_q, fill_done_d;
    logic                        rsp_valid_q, rsp_valid_d;
    logic                        rsp_misaligned_q, rsp_misaligned_d;
    logic [XLEN-1:0]             rsp_rdata_q, rsp_rdata_d;

    logic                        req_fire;
    logic                        misaligned;
    logic                        store_fire;
    logic                        fill_write;
    logic [ADDR_W-1:0]           addr;
    logic [XLEN-1:0]             rd_word;
    logic [XLEN-1:0]             wr_word;
    logic [XLEN-1:0]             load_data;
    logic [LANES-1:0]            wr_en;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q          <= IDLE;
            cnt_q            <= '0;
            line_set_q       <= '0;
            line_way_q       <= '0;
            fill_done_q      <= 1'b0;
            rsp_valid_q      <= 1'b0;
            rsp_misaligned_q <= 1'b0;
            rsp_rdata_q      <= '0;
        end else begin
            state_q          <= state_d;
            cnt_q            <= cnt_d;
            line_set_q       <= line_set_d;
            line_way_q       <= line_way_d;
            fill_done_q      <= fill_done_d;
            rsp_valid_q      <= rsp_valid_d;
            rsp_misaligned_q <= rsp_misaligned_d;
            rsp_rdata_q      <= rsp_rdata_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        line_set_d  = line_set_q;
        line_way_d  = line_way_q;
        fill_done_d = 1'b0;
        case (state_q)
            IDLE: begin
                // Evict takes priority so a dirty victim leaves before its replacement arrives.
                if (evict_start) begin
                    state_d    = EVICT;
                    line_set_d = evict_set;
                    line_way_d = evict_way;
                    cnt_d      = '0;
                end else if (fill_start) begin
                    state_d    = FILL;
                    line_set_d = fill_set;
                    line_way_d = fill_way;
                    cnt_d      = '0;
                end
            end
            FILL: begin
                if (fill_valid) begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == LAST_WORD) begin
                        state_d     = IDLE;
                        fill_done_d = 1'b1;
                    end
                end
            end
            EVICT: begin
                if (evict_ready) begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == LAST_WORD) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        req_ready   = (state_q == IDLE) && !fill_start && !evict_start;
        evict_valid = (state_q == EVICT);
        evict_last  = (state_q == EVICT) && (cnt_q == LAST_WORD);
        fill_done   = fill_done_q;
    end

    always_comb begin
        req_fire = req_valid && req_ready;
        case (req_size)
            BYTE:    misaligned = 1'b0;
            HALF:    misaligned = req_byte[0];
            default: misaligned = (req_byte != '0);
        endcase
        store_fire = req_fire && req_write && !misaligned;
        fill_write = (state_q == FILL) && fill_valid;
        // Core accesses only happen in IDLE, so one shared array port suffices.
        addr = (state_q == IDLE) ? {req_way, req_set, req_word}
                                 : {line_way_q, line_set_q, cnt_q};
        if (fill_write) begin
            wr_word = fill_data;
        end else begin
            case (req_size)
                BYTE:    wr_word = {LANES{req_wdata[BYTE_WIDTH-1:0]}};
                HALF:    wr_word = {(LANES/2){req_wdata[HALF_WIDTH-1:0]}};
                default: wr_word = req_wdata;
            endcase
        end
    end

    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        localparam logic [BYTE_SELECT_SIZE-1:0] LANE_IDX = BYTE_SELECT_SIZE'(gi);
        logic [7:0] lane_mem [DEPTH];

        assign wr_en[gi] = fill_write ||
                           (store_fire &&
                            ((req_size == BYTE) ? (LANE_IDX == req_byte) :
                             (req_size == HALF) ? (LANE_IDX[BYTE_SELECT_SIZE-1:1] ==
                                                   req_byte[BYTE_SELECT_SIZE-1:1]) :
                                                  1'b1));

        always_ff @(posedge clk) begin
            if (wr_en[gi]) begin
                lane_mem[addr] <= wr_word[gi*8 +: 8];
            end
        end

        assign rd_word[gi*8 +: 8] = lane_mem[addr];
    end

    cache_data_ways_load_extend #(
        .XLEN             (XLEN),
        .BYTE_SELECT_SIZE (BYTE_SELECT_SIZE)
    ) u_load_extend (
        .word_i     (rd_word),
        .byte_sel_i (req_byte),
        .size_i     (req_size),
        .unsigned_i (req_unsigned),
        .data_o     (load_data)
    );

    always_comb begin
        rsp_valid_d      = req_fire;
        rsp_misaligned_d = req_fire && misaligned;
        rsp_rdata_d      = (req_fire && !req_write && !misaligned) ? load_data : '0;
    end

    assign rsp_valid      = rsp_valid_q;
    assign rsp_misaligned = rsp_misaligned_q;
    assign rsp_rdata      = rsp_rdata_q;
    assign evict_data     = rd_word;

endmodule

// File: tb/tb_cache_data_ways.sv
// Self-checking bench for cache_data_ways: directed scenarios plus random
// traffic, checked every cycle against a line-array reference model.
module tb_cache_data_ways;
    import cache_data_ways_pkg::*;

    localparam int XLEN = 32;
    localparam int NW   = 2;
    localparam int NS   = 4;
    localparam int WPL  = 8;

    logic                   clk = 1'b0;
    logic                   reset_n;
    logic                   req_valid, req_ready, req_write;
    logic [1:0]             req_set;
    logic [0:0]             req_way;
    logic [2:0]             req_word;
    logic [1:0]             req_byte;
    memory_operation_size_e req_size;
    logic                   req_unsigned;
    logic [XLEN-1:0]        req_wdata;
    logic                   rsp_valid, rsp_misaligned;
    logic [XLEN-1:0]        rsp_rdata;
    logic                   fill_start, fill_valid, fill_done;
    logic [1:0]             fill_set;
    logic [0:0]             fill_way;
    logic [XLEN-1:0]        fill_data;
    logic                   evict_start, evict_valid, evict_ready, evict_last;
    logic [1:0]             evict_set;
    logic [0:0]             evict_way;
    logic [XLEN-1:0]        evict_data;

    cache_data_ways #(
        .XLEN(XLEN), .NUM_WAYS(NW), .NUM_SETS(NS), .WORDS_PER_LINE(WPL)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_set(req_set), .req_way(req_way), .req_word(req_word), .req_byte(req_byte),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_misaligned(rsp_misaligned),
        .fill_start(fill_start), .fill_set(fill_set), .fill_way(fill_way),
        .fill_valid(fill_valid), .fill_data(fill_data), .fill_done(fill_done),
        .evict_start(evict_start), .evict_set(evict_set), .evict_way(evict_way),
        .evict_valid(evict_valid), .evict_ready(evict_ready), .evict_data(evict_data),
        .evict_last(evict_last)
    );

    always #5 clk = ~clk;

    // Reference model state
    logic [XLEN-1:0] mem_m [NW][NS][WPL];
    int  checks = 0;
    int  errors = 0;
    bit  pend = 0, pend_mis = 0, fd_exp = 0, filling = 0, evicting = 0;
    logic [XLEN-1:0] pend_data = '0;
    int  m_set = 0, m_way = 0, m_cnt = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic bit ref_misaligned(memory_operation_size_e sz, int b);
        if (sz == BYTE) return 1'b0;
        if (sz == HALF) return (b % 2) != 0;
        return b != 0;
    endfunction

    function automatic logic [31:0] ref_load(logic [31:0] w, int b, memory_operation_size_e sz, bit uns);
        logic [31:0] v;
        if (sz == BYTE) begin
            v = (w >> (8 * b)) & 32'hFF;
            if (!uns && v[7]) v = v | 32'hFFFFFF00;
        end else if (sz == HALF) begin
            v = (w >> (8 * b)) & 32'hFFFF;
            if (!uns && v[15]) v = v | 32'hFFFF0000;
        end else begin
            v = w;
        end
        return v;
    endfunction

    function automatic logic [31:0] ref_store(logic [31:0] w, int b, memory_operation_size_e sz, logic [31:0] d);
        logic [31:0] mask;
        if (sz == BYTE)      mask = 32'hFF << (8 * b);
        else if (sz == HALF) mask = 32'hFFFF << (8 * b);
        else                 mask = 32'hFFFFFFFF;
        return (w & ~mask) | ((d << (8 * b)) & mask);
    endfunction

    // One clock cycle: check outputs against the model, then advance the model.
    task automatic tick();
        bit busy;
        bit mis;
        int b;
        @(negedge clk);
        busy = filling || evicting;
        check_eq("rsp_valid", 32'(rsp_valid), 32'(pend));
        if (pend) begin
            check_eq("rsp_rdata", rsp_rdata, pend_data);
            check_eq("rsp_misaligned", 32'(rsp_misaligned), 32'(pend_mis));
        end
        check_eq("fill_done", 32'(fill_done), 32'(fd_exp));
        check_eq("req_ready", 32'(req_ready), 32'(!busy && !fill_start && !evict_start));
        check_eq("evict_valid", 32'(evict_valid), 32'(evicting));
        if (evicting) begin
            check_eq("evict_data", evict_data, mem_m[m_way][m_set][m_cnt]);
            check_eq("evict_last", 32'(evict_last), 32'(m_cnt == WPL - 1));
        end
        fd_exp = 0;
        pend   = 0;
        if (filling) begin
            if (fill_valid) begin
                mem_m[m_way][m_set][m_cnt] = fill_data;
                m_cnt++;
                if (m_cnt == WPL) begin
                    filling = 0;
                    fd_exp  = 1;
                end
            end
        end else if (evicting) begin
            if (evict_ready) begin
                m_cnt++;
                if (m_cnt == WPL) evicting = 0;
            end
        end else if (evict_start) begin
            evicting = 1; m_set = int'(evict_set); m_way = int'(evict_way); m_cnt = 0;
            $display("evict start set=%0d way=%0d", m_set, m_way);
        end else if (fill_start) begin
            filling = 1; m_set = int'(fill_set); m_way = int'(fill_way); m_cnt = 0;
            $display("fill start set=%0d way=%0d", m_set, m_way);
        end else if (req_valid) begin
            b        = int'(req_byte);
            mis      = ref_misaligned(req_size, b);
            pend     = 1;
            pend_mis = mis;
            pend_data = (req_write || mis) ? 32'h0 :
                        ref_load(mem_m[req_way][req_set][req_word], b, req_size, req_unsigned);
            if (req_write && !mis)
                mem_m[req_way][req_set][req_word] =
                    ref_store(mem_m[req_way][req_set][req_word], b, req_size, req_wdata);
            $display("%s set=%0d way=%0d word=%0d byte=%0d %s uns=%0d wdata=%h exp_rdata=%h mis=%0d",
                     req_write ? "st" : "ld", req_set, req_way, req_word, b, req_size.name(),
                     req_unsigned, req_wdata, pend_data, mis);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic quiet_inputs();
        req_valid = 0; req_write = 0; req_set = 0; req_way = 0; req_word = 0; req_byte = 0;
        req_size = WORD; req_unsigned = 0; req_wdata = '0;
        fill_start = 0; fill_set = 0; fill_way = 0; fill_valid = 0; fill_data = '0;
        evict_start = 0; evict_set = 0; evict_way = 0; evict_ready = 0;
    endtask

    task automatic reset_checks();
        check_eq("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        check_eq("rst_rsp_rdata", rsp_rdata, 32'h0);
        check_eq("rst_rsp_misaligned", 32'(rsp_misaligned), 32'h0);
        check_eq("rst_fill_done", 32'(fill_done), 32'h0);
        check_eq("rst_evict_valid", 32'(evict_valid), 32'h0);
        check_eq("rst_req_ready", 32'(req_ready), 32'h1);
    endtask

    // Called at posedge+1; asserts reset asynchronously mid-cycle.
    task automatic apply_reset();
        quiet_inputs();
        reset_n = 0;
        #2;
        reset_checks();
        @(posedge clk);
        #1;
        reset_n  = 1;
        pend     = 0;
        fd_exp   = 0;
        filling  = 0;
        evicting = 0;
    endtask

    task automatic fill_line(input int s, input int w, input bit plan);
        fill_start = 1; fill_set = 2'(s); fill_way = 1'(w);
        req_valid = 1; req_write = 0; req_set = 2'(s); req_way = 1'(w);
        tick();
        fill_start = 0;
        for (int i = 0; i < WPL; i++) begin
            if (plan) begin
                fill_valid = 0; fill_data = $urandom; tick();
            end else begin
                while ($urandom_range(0, 2) == 0) begin
                    fill_valid = 0; fill_data = $urandom; tick();
                end
            end
            fill_valid = 1;
            fill_data  = plan ? 32'h11111111 * 32'(i + 1) : 32'($urandom);
            tick();
        end
        fill_valid = 0; req_valid = 0;
        tick();
        tick();
    endtask

    task automatic op(input bit wr, input int s, input int w, input int wd, input int b,
                      input memory_operation_size_e sz, input bit uns, input logic [31:0] d);
        req_valid = 1; req_write = wr; req_set = 2'(s); req_way = 1'(w); req_word = 3'(wd);
        req_byte = 2'(b); req_size = sz; req_unsigned = uns; req_wdata = d;
        tick();
    endtask

    task automatic idle_cycle();
        req_valid = 0;
        tick();
    endtask

    initial begin
        int n;
        quiet_inputs();
        reset_n = 1;
        #1 reset_n = 0;
        #2;
        reset_checks();
        @(posedge clk);
        #1 reset_n = 1;

        // Populate every line so all later reads have defined expectations.
        for (int s = 0; s < NS; s++)
            for (int w = 0; w < NW; w++)
                fill_line(s, w, (s == 2 && w == 1));

        op(0, 2, 1, 3, 0, WORD, 0, 0);
        idle_cycle();

        op(1, 1, 0, 5, 0, WORD, 0, 32'h80FF0000);
        op(0, 1, 0, 5, 3, BYTE, 0, 0);
        op(0, 1, 0, 5, 3, BYTE, 1, 0);
        idle_cycle();

        op(1, 0, 1, 2, 0, WORD, 0, 32'h12345678);
        op(1, 0, 0, 2, 0, WORD, 0, 32'hCAFED00D);
        op(1, 0, 1, 2, 2, HALF, 0, 32'h0000BEEF);
        op(0, 0, 1, 2, 0, WORD, 0, 0);
        op(0, 0, 0, 2, 0, WORD, 0, 0);
        idle_cycle();

        op(1, 0, 1, 2, 1, WORD, 0, 32'hDEADBEEF);
        op(0, 0, 1, 2, 0, WORD, 0, 0);
        op(0, 0, 1, 2, 1, HALF, 0, 0);
        idle_cycle();

        evict_start = 1; evict_set = 2; evict_way = 1; evict_ready = 0;
        tick();
        evict_start = 0;
        repeat (3) tick();
        evict_ready = 1;
        n = 0;
        while (evicting && n < 20) begin
            tick();
            n++;
        end
        check_eq("evict_complete", 32'(evicting), 32'h0);
        evict_ready = 0;
        tick();

        for (int c = 0; c < 400; c++) begin
            req_valid = 1'($urandom_range(0, 1)); req_write = 1'($urandom_range(0, 1));
            req_set = 2'($urandom); req_way = 1'($urandom); req_word = 3'($urandom);
            req_byte = 2'($urandom); req_size = memory_operation_size_e'($urandom_range(0, 2));
            req_unsigned = 1'($urandom); req_wdata = $urandom;
            fill_start = ($urandom_range(0, 19) == 0); fill_set = 2'($urandom); fill_way = 1'($urandom);
            evict_start = ($urandom_range(0, 19) == 0); evict_set = 2'($urandom); evict_way = 1'($urandom);
            fill_valid = 1'($urandom); fill_data = $urandom; evict_ready = 1'($urandom);
            tick();
        end
        quiet_inputs();
        fill_valid = 1; fill_data = $urandom; evict_ready = 1;
        n = 0;
        while ((filling || evicting) && n < 40) begin
            fill_data = $urandom;
            tick();
            n++;
        end
        check_eq("drain_idle", 32'(filling || evicting), 32'h0);
        quiet_inputs();
        tick();
        tick();

        fill_start = 1; fill_set = 1; fill_way = 1;
        evict_start = 1; evict_set = 3; evict_way = 0;
        tick();
        fill_start = 0; evict_start = 0; evict_ready = 1;
        tick();
        tick();
        tick();
        apply_reset();
        tick();
        op(0, 3, 0, 0, 0, WORD, 0, 0);
        op(0, 1, 1, 7, 2, HALF, 1, 0);
        idle_cycle();
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
